decode_stage: RTL

Instruction decode stage of the simple CPU, directly upstream of `regbank`. It accepts RV32I instructions from fetch over a valid/ready handshake and drives both `regbank` read ports. Register read-after-write and write-after-write hazards are tracked with a pending-write scoreboard. Operands, immediate and control are registered into the ID/EX pipeline register for execute.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/imm_gen.sv | 35 +++
 rtl/decode_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the simple CPU pipeline.
//   - default datapath width and architectural register count
//   - RV32I major opcodes (instr[6:0])
//   - immediate format selector used by the decode stage and imm_gen
package cpu_pkg;

  localparam int DATAWIDTH_DEF = 32;
  localparam int NUMREGS_DEF   = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction for RV32I.
// Ports:
//   instr_i  in   instruction bits [31:7] (opcode field is not needed here)
//   fmt_i    in   immediate format selected by the decoder
//   imm_o    out  immediate sign-extended from instr bit 31 to DATAWIDTH
module imm_gen
  import cpu_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [31:7]          instr_i,
  input  imm_fmt_e             fmt_i,
  output logic [DATAWIDTH-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widening cast of a signed value replicates bit 31 when DATAWIDTH > 32.
  assign imm_o = DATAWIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode, sitting just upstream of regbank.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   if_valid_i/if_ready_o        fetch handshake; if_instr_i, if_pc_i payload
//   rb_re_*_o, rb_raddr_*_o      regbank read ports (rs1 -> a, rs2 -> b)
//   rb_rdata_*_i                 regbank read data, same cycle as the address
//   wb_we_i, wb_waddr_i          snoop of the regbank write port
//   sb_clr_i, sb_clr_addr_i      downstream kill of a pending writer
//   flush_i                      discard the ID/EX register contents
//   ex_valid_o/ex_ready_i        execute handshake
//   ex_rs1_o..ex_we_o            registered ID/EX payload
// A pending-write scoreboard holds back any instruction whose sources or
// destination still have an in-flight writer.
module decode_stage #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [DATAWIDTH-1:0]       if_instr_i,
  input  logic [DATAWIDTH-1:0]       if_pc_i,
  output logic                       rb_re_a_o,
  output logic                       rb_re_b_o,
  output logic [$clog2(NUMREGS)-1:0] rb_raddr_a_o,
  output logic [$clog2(NUMREGS)-1:0] rb_raddr_b_o,
  input  logic [DATAWIDTH-1:0]       rb_rdata_a_i,
  input  logic [DATAWIDTH-1:0]       rb_rdata_b_i,
  input  logic                       wb_we_i,
  input  logic [$clog2(NUMREGS)-1:0] wb_waddr_i,
  input  logic                       sb_clr_i,
  input  logic [$clog2(NUMREGS)-1:0] sb_clr_addr_i,
  input  logic                       flush_i,
  output logic                       ex_valid_o,
  input  logic                       ex_ready_i,
  output logic [DATAWIDTH-1:0]       ex_rs1_o,
  output logic [DATAWIDTH-1:0]       ex_rs2_o,
  output logic [DATAWIDTH-1:0]       ex_imm_o,
  output logic [DATAWIDTH-1:0]       ex_instr_o,
  output logic [DATAWIDTH-1:0]       ex_pc_o,
  output logic [$clog2(NUMREGS)-1:0] ex_rd_o,
  output logic                       ex_we_o
);

  import cpu_pkg::*;

  localparam int AW = $clog2(NUMREGS);

  logic [6:0]           opcode;
  logic [AW-1:0]        rs1, rs2, rd;
  logic                 use_rs1, use_rs2, wr_rd, writes_rd;
  imm_fmt_e             fmt;
  logic [DATAWIDTH-1:0] imm;

  logic                 bypass_a, bypass_b, hazard, accept;

  logic [NUMREGS-1:0]   pend_q, pend_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [DATAWIDTH-1:0] ex_rs1_q, ex_rs1_d;
  logic [DATAWIDTH-1:0] ex_rs2_q, ex_rs2_d;
  logic [DATAWIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [DATAWIDTH-1:0] ex_instr_q, ex_instr_d;
  logic [DATAWIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [AW-1:0]        ex_rd_q, ex_rd_d;
  logic                 ex_we_q, ex_we_d;

  assign opcode = if_instr_i[6:0];
  assign rs1    = AW'(if_instr_i[19:15]);
  assign rs2    = AW'(if_instr_i[24:20]);
  assign rd     = AW'(if_instr_i[11:7]);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    fmt     = IMM_NONE;
    case (opcode)
      OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_IMM: begin use_rs1 = 1'b1; wr_rd = 1'b1; fmt = IMM_I; end
      LOAD:   begin use_rs1 = 1'b1; wr_rd = 1'b1; fmt = IMM_I; end
      JALR:   begin use_rs1 = 1'b1; wr_rd = 1'b1; fmt = IMM_I; end
      STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S; end
      BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B; end
      LUI:    begin wr_rd = 1'b1; fmt = IMM_U; end
      AUIPC:  begin wr_rd = 1'b1; fmt = IMM_U; end
      JAL:    begin wr_rd = 1'b1; fmt = IMM_J; end
      default: ;
    endcase
  end

  // Writes to x0 are architecturally discarded, so they never occupy the scoreboard.
  assign writes_rd = wr_rd & (rd != '0);

  imm_gen #(.DATAWIDTH(DATAWIDTH)) u_imm_gen (
    .instr_i (if_instr_i[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  assign rb_re_a_o    = use_rs1 & if_valid_i;
  assign rb_re_b_o    = use_rs2 & if_valid_i;
  assign rb_raddr_a_o = rs1;
  assign rb_raddr_b_o = rs2;

  // A source being written back this very cycle is forwarded by regbank, so
  // its pending bit need not stall. The destination check has no such bypass.
  assign bypass_a = wb_we_i & (wb_waddr_i == rs1);
  assign bypass_b = wb_we_i & (wb_waddr_i == rs2);
  assign hazard   = (use_rs1 & pend_q[rs1] & ~bypass_a)
                  | (use_rs2 & pend_q[rs2] & ~bypass_b)
                  | (writes_rd & pend_q[rd]);

  assign if_ready_o = ~rst_i & ~flush_i & ~hazard & (~ex_valid_q | ex_ready_i);
  assign accept     = if_valid_i & if_ready_o;

  // ID/EX next state: flush beats accept, accept beats drain.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_rs1_d   = rb_rdata_a_i;
      ex_rs2_d   = rb_rdata_b_i;
      ex_imm_d   = imm;
      ex_instr_d = if_instr_i;
      ex_pc_d    = if_pc_i;
      ex_rd_d    = rd;
      ex_we_d    = writes_rd;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  // Scoreboard next state: clears first, then the set, so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_we_i) pend_d[wb_waddr_i] = 1'b0;
    if (sb_clr_i) pend_d[sb_clr_addr_i] = 1'b0;
    if (flush_i && ex_valid_q && ex_we_q) pend_d[ex_rd_q] = 1'b0;
    if (accept && writes_rd) pend_d[rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_instr_q <= '0;
      ex_pc_q    <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      ex_valid_q <= ex_valid_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_rs1_o   = ex_rs1_q;
  assign ex_rs2_o   = ex_rs2_q;
  assign ex_imm_o   = ex_imm_q;
  assign ex_instr_o = ex_instr_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_rd_o    = ex_rd_q;
  assign ex_we_o    = ex_we_q;

endmodule
